// File: rtl/pos_cell_ctrl_pkg.sv
// Shared definitions for the position cell RAM controller: FSM encoding,
// RAM read latency and the particle-count saturation helper.
package pos_cell_ctrl_pkg;

    typedef enum logic [1:0] {
        S_INIT_RD   = 2'd0,
        S_INIT_WAIT = 2'd1,
        S_IDLE      = 2'd2,
        S_BURST     = 2'd3
    } cell_state_e;

    localparam int unsigned RD_LATENCY = 2;

    function automatic int unsigned sat_count(input int unsigned value, input int unsigned limit);
        return (value > limit) ? limit : value;
    endfunction

endpackage

// File: rtl/pos_rd_delay.sv
// Delay line that realigns read-issue tags (valid/index/last) with the
// RAM output, RD_LATENCY cycles after the read was issued.
module pos_rd_delay
    import pos_cell_ctrl_pkg::*;
#(
    parameter int unsigned IDX_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_valid,
    input  logic [IDX_WIDTH-1:0] i_index,
    input  logic                 i_last,
    output logic                 o_valid,
    output logic [IDX_WIDTH-1:0] o_index,
    output logic                 o_last
);

    logic [RD_LATENCY-1:0]                r_valid;
    logic [RD_LATENCY-1:0]                r_last;
    logic [RD_LATENCY-1:0][IDX_WIDTH-1:0] r_index;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_last  <= '0;
            r_index <= '0;
        end else begin
            r_valid <= {r_valid[RD_LATENCY-2:0], i_valid};
            r_last  <= {r_last[RD_LATENCY-2:0], i_last};
            r_index <= {r_index[RD_LATENCY-2:0], i_index};
        end
    end

    assign o_valid = r_valid[RD_LATENCY-1];
    assign o_last  = r_last[RD_LATENCY-1];
    assign o_index = r_index[RD_LATENCY-1];

endmodule

// File: rtl/pos_cell_ctrl.sv
// Position cell RAM controller: loads the particle count from address 0,
// then streams particle words 1..count on request, interleaving writes.
module pos_cell_ctrl
    import pos_cell_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 96,
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned PARTICLE_NUM = 220
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  burst_start,
    output logic                  busy,
    output logic                  init_done,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH-1:0] rd_index,
    output logic                  burst_done,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_gnt,
    output logic [ADDR_WIDTH-1:0] particle_cnt,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_rden,
    output logic                  mem_wren,
    input  logic [DATA_WIDTH-1:0] mem_q
);

    localparam int unsigned CNT_MAX = PARTICLE_NUM - 1;

    cell_state_e           r_state;
    logic                  r_init_arm;
    logic                  r_wait;
    logic                  r_init_done;
    logic                  r_busy;
    logic                  r_zero_done;
    logic                  r_prev_rd;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_burst_len;
    logic [ADDR_WIDTH-1:0] r_particle_cnt;

    logic                  w_wr_gnt;
    logic                  w_rd_issue;
    logic                  w_burst_rd;
    logic                  w_burst_last;
    logic                  w_burst_done;
    logic                  w_dly_valid;
    logic                  w_dly_last;
    logic [ADDR_WIDTH-1:0] w_dly_index;
    logic [ADDR_WIDTH-1:0] w_wr_cnt;
    logic [ADDR_WIDTH-1:0] w_init_cnt;

    assign w_wr_cnt   = ADDR_WIDTH'(sat_count(32'(wr_data[ADDR_WIDTH-1:0]), CNT_MAX));
    assign w_init_cnt = ADDR_WIDTH'(sat_count(32'(mem_q[ADDR_WIDTH-1:0]), CNT_MAX));

    // RAM port arbitration: in BURST a pending write only wins after a read cycle
    always_comb begin
        w_wr_gnt    = 1'b0;
        w_rd_issue  = 1'b0;
        mem_address = '0;
        case (r_state)
            S_INIT_RD: w_rd_issue = r_init_arm;
            S_IDLE:    w_wr_gnt   = wr_req;
            S_BURST: begin
                w_wr_gnt   = wr_req & r_prev_rd;
                w_rd_issue = ~(wr_req & r_prev_rd);
            end
            default: ;
        endcase
        if (w_wr_gnt) begin
            mem_address = wr_addr;
        end else if (r_state == S_BURST) begin
            mem_address = r_addr;
        end
    end

    assign w_burst_rd   = w_rd_issue && (r_state == S_BURST);
    assign w_burst_last = w_burst_rd && (r_addr == r_burst_len);
    assign w_burst_done = w_dly_last | r_zero_done;

    // r_init_arm delays the count read to the first full cycle after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_INIT_RD;
            r_init_arm     <= 1'b0;
            r_wait         <= 1'b0;
            r_init_done    <= 1'b0;
            r_busy         <= 1'b1;
            r_zero_done    <= 1'b0;
            r_prev_rd      <= 1'b0;
            r_addr         <= '0;
            r_burst_len    <= '0;
            r_particle_cnt <= '0;
        end else begin
            r_init_arm  <= 1'b1;
            r_zero_done <= 1'b0;
            r_prev_rd   <= w_rd_issue;
            if (w_burst_done) begin
                r_busy <= 1'b0;
            end
            if (w_wr_gnt && (wr_addr == '0)) begin
                r_particle_cnt <= w_wr_cnt;
            end
            case (r_state)
                S_INIT_RD: begin
                    if (r_init_arm) begin
                        r_state <= S_INIT_WAIT;
                        r_wait  <= 1'b0;
                    end
                end
                S_INIT_WAIT: begin
                    if (r_wait) begin
                        r_particle_cnt <= w_init_cnt;
                        r_init_done    <= 1'b1;
                        r_busy         <= 1'b0;
                        r_state        <= S_IDLE;
                    end else begin
                        r_wait <= 1'b1;
                    end
                end
                S_IDLE: begin
                    if (burst_start && !r_busy) begin
                        r_busy <= 1'b1;
                        if (r_particle_cnt == '0) begin
                            r_zero_done <= 1'b1;
                        end else begin
                            r_addr      <= ADDR_WIDTH'(1);
                            r_burst_len <= r_particle_cnt;
                            r_state     <= S_BURST;
                        end
                    end
                end
                S_BURST: begin
                    if (w_rd_issue) begin
                        r_addr <= r_addr + ADDR_WIDTH'(1);
                        if (r_addr == r_burst_len) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_INIT_RD;
            endcase
        end
    end

    pos_rd_delay #(
        .IDX_WIDTH (ADDR_WIDTH)
    ) u_rd_delay (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (w_burst_rd),
        .i_index (r_addr),
        .i_last  (w_burst_last),
        .o_valid (w_dly_valid),
        .o_index (w_dly_index),
        .o_last  (w_dly_last)
    );

    assign mem_rden     = w_rd_issue;
    assign mem_wren     = w_wr_gnt;
    assign mem_data     = wr_data;
    assign wr_gnt       = w_wr_gnt;
    assign rd_valid     = w_dly_valid;
    assign rd_index     = w_dly_index;
    assign rd_data      = mem_q;
    assign burst_done   = w_burst_done;
    assign busy         = r_busy;
    assign init_done    = r_init_done;
    assign particle_cnt = r_particle_cnt;

endmodule
